// File: rtl/bus_pkg.sv
// Shared types and helpers for the N-device bus hub and its address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } hub_state_t;

  // Read data handed back to the host on an error completion.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  localparam int BYTE_W = 8;

  // Byte-enable width for a given data width.
  function automatic int mask_w(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Width of a device index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_hub_n_pl_if.sv
// Host-side and device-side signal bundle of the N-device bus hub.
// The slave modport is the hub's view; the master modport is the
// view of whoever drives the host requests and models the devices.
interface bus_hub_n_pl_if
  import bus_pkg::*;
#(
  parameter int N_DEVICES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  localparam int MASK_W = mask_w(DATA_W);

  logic [ADDR_W-1:0]           host_address;
  logic [DATA_W-1:0]           host_data_write;
  logic [MASK_W-1:0]           host_write_mask;
  logic                        host_wen;
  logic                        host_ren;
  logic [DATA_W-1:0]           host_data_read;
  logic                        host_ready;
  logic                        host_error;

  logic [N_DEVICES*ADDR_W-1:0] device_address;
  logic [N_DEVICES*DATA_W-1:0] device_data_write;
  logic [N_DEVICES*MASK_W-1:0] device_write_mask;
  logic [N_DEVICES-1:0]        device_ren;
  logic [N_DEVICES-1:0]        device_wen;
  logic [N_DEVICES-1:0]        device_ready;
  logic [N_DEVICES*DATA_W-1:0] device_data_read;

  modport slave (
    input  host_address, host_data_write, host_write_mask, host_wen, host_ren,
    output host_data_read, host_ready, host_error,
    output device_address, device_data_write, device_write_mask,
    output device_ren, device_wen,
    input  device_ready, device_data_read
  );

  modport master (
    output host_address, host_data_write, host_write_mask, host_wen, host_ren,
    input  host_data_read, host_ready, host_error,
    input  device_address, device_data_write, device_write_mask,
    input  device_ren, device_wen,
    output device_ready, device_data_read
  );

endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational priority address decoder: device i matches when
// (addr & mask[i]) == base[i]; the lowest matching index wins.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                          N_DEVICES = 4,
  parameter int                          ADDR_W    = 32,
  parameter logic [N_DEVICES*ADDR_W-1:0] DEV_BASE  = '0,
  parameter logic [N_DEVICES*ADDR_W-1:0] DEV_MASK  = '0
) (
  input  logic [ADDR_W-1:0]           addr,
  output logic [N_DEVICES-1:0]        sel_onehot,
  output logic                        sel_valid,
  output logic [idx_w(N_DEVICES)-1:0] sel_idx
);

  localparam int IDX_W = idx_w(N_DEVICES);

  // First match in ascending index order claims the select.
  always_comb begin
    sel_onehot = '0;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      if (!sel_valid &&
          ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel_valid     = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_hub_n_pl.sv
// N-device bus hub: one host transaction at a time through IDLE/ACTIVE/RESP,
// with internal address decode, per-transaction timeout and error status.
module bus_hub_n_pl
  import bus_pkg::*;
#(
  parameter int                          N_DEVICES      = 4,
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 32,
  parameter logic [N_DEVICES*ADDR_W-1:0] DEV_BASE       = '0,
  parameter logic [N_DEVICES*ADDR_W-1:0] DEV_MASK       = '0,
  parameter int unsigned                 TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]           ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  bus_hub_n_pl_if.slave      bus,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  err_addr
);

  localparam int MASK_W = mask_w(DATA_W);
  localparam int IDX_W  = idx_w(N_DEVICES);
  localparam int TMO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  hub_state_t           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [MASK_W-1:0]    mask_q, mask_d;
  logic                 is_write_q, is_write_d;
  logic [N_DEVICES-1:0] sel_oh_q, sel_oh_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [15:0]          err_count_q, err_count_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

  logic [N_DEVICES-1:0] dec_onehot;
  logic                 dec_valid;
  logic [IDX_W-1:0]     dec_idx;
  logic                 ready_sel;
  logic [DATA_W-1:0]    rdata_sel;
  logic [TMO_W-1:0]     tmo_inc;

  bus_addr_decoder #(
    .N_DEVICES (N_DEVICES),
    .ADDR_W    (ADDR_W),
    .DEV_BASE  (DEV_BASE),
    .DEV_MASK  (DEV_MASK)
  ) u_decoder (
    .addr       (bus.host_address),
    .sel_onehot (dec_onehot),
    .sel_valid  (dec_valid),
    .sel_idx    (dec_idx)
  );

  // Ready and read data of the latched target; other devices are ignored.
  always_comb begin
    ready_sel = bus.device_ready[sel_q];
    rdata_sel = bus.device_data_read[int'(sel_q)*DATA_W +: DATA_W];
    tmo_inc   = tmo_q + 1'b1;
  end

  // Next-state, latching and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    is_write_d  = is_write_q;
    sel_oh_d    = sel_oh_q;
    sel_d       = sel_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    tmo_d       = tmo_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.host_wen || bus.host_ren) begin
          addr_d     = bus.host_address;
          wdata_d    = bus.host_data_write;
          mask_d     = bus.host_write_mask;
          is_write_d = bus.host_wen;
          sel_oh_d   = dec_onehot;
          sel_d      = dec_idx;
          if (dec_valid) begin
            err_d   = 1'b0;
            state_d = ACTIVE;
          end else begin
            err_d       = 1'b1;
            resp_data_d = bus.host_wen ? '0 : ERR_RDATA;
            state_d     = RESP;
          end
        end
      end

      ACTIVE: begin
        tmo_d = tmo_inc;
        // Ready is tested first so it wins over a coincident timeout.
        if (ready_sel) begin
          err_d       = 1'b0;
          resp_data_d = is_write_q ? '0 : rdata_sel;
          state_d     = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_W'(TIMEOUT_CYCLES))) begin
          err_d       = 1'b1;
          resp_data_d = is_write_q ? '0 : ERR_RDATA;
          state_d     = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
        if (err_q) begin
          err_addr_d = addr_q;
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      is_write_q  <= 1'b0;
      sel_oh_q    <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      tmo_q       <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      is_write_q  <= is_write_d;
      sel_oh_q    <= sel_oh_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      tmo_q       <= tmo_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Strobes are live only in ACTIVE; host outputs only in RESP.
  always_comb begin
    bus.device_address    = {N_DEVICES{addr_q}};
    bus.device_data_write = {N_DEVICES{wdata_q}};
    bus.device_write_mask = {N_DEVICES{mask_q}};
    bus.device_ren        = ((state_q == ACTIVE) && !is_write_q) ? sel_oh_q : '0;
    bus.device_wen        = ((state_q == ACTIVE) &&  is_write_q) ? sel_oh_q : '0;
    bus.host_ready        = (state_q == RESP);
    bus.host_error        = (state_q == RESP) && err_q;
    bus.host_data_read    = (state_q == RESP) ? resp_data_q : '0;
    err_count             = err_count_q;
    err_addr              = err_addr_q;
  end

endmodule

// File: tb/tb_bus_hub_n_pl.sv
// Directed bench for bus_hub_n_pl: four devices, two overlapping, timeout 8.
module tb_bus_hub_n_pl;

  localparam int N = 4;
  localparam logic [N*32-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_8000};

  logic        clk;
  logic        rst;
  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic [N-1:0] silent;

  int unsigned n_checks;
  int unsigned n_fail;

  bus_hub_n_pl_if #(.N_DEVICES(N), .ADDR_W(32), .DATA_W(32)) bif ();

  bus_hub_n_pl #(
    .N_DEVICES      (N),
    .ADDR_W         (32),
    .DATA_W         (32),
    .DEV_BASE       (BASE),
    .DEV_MASK       (MASK),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device models: one-cycle ready pulse the cycle after the strobe is seen.
  always_ff @(posedge clk) begin
    if (!rst) bif.device_ready <= '0;
    else      bif.device_ready <= (bif.device_ren | bif.device_wen) & ~bif.device_ready & ~silent;
  end

  assign bif.device_data_read = {32'h4444_4444, 32'h3333_3333, 32'hCAFE_0001, 32'h1234_5678};

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_host();
    bif.host_wen = 1'b0;
    bif.host_ren = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    silent   = '0;
    bif.host_address    = '0;
    bif.host_data_write = '0;
    bif.host_write_mask = '0;
    idle_host();
    tick(); tick(); tick();

    check_eq("rst_ready",  {127'b0, bif.host_ready}, 128'd0);
    check_eq("rst_error",  {127'b0, bif.host_error}, 128'd0);
    check_eq("rst_rdata",  {96'b0, bif.host_data_read}, 128'd0);
    check_eq("rst_strobe", {120'b0, bif.device_ren, bif.device_wen}, 128'd0);
    check_eq("rst_errcnt", {112'b0, err_count}, 128'd0);
    check_eq("rst_erradr", {96'b0, err_addr}, 128'd0);
    rst = 1'b1;
    tick();

    // Read from device 0.
    bif.host_address = 32'h0000_0010;
    bif.host_ren     = 1'b1;
    tick();
    check_eq("rd_ren_c1",  {124'b0, bif.device_ren}, 128'b0001);
    check_eq("rd_rdy_c1",  {127'b0, bif.host_ready}, 128'd0);
    tick();
    check_eq("rd_rdy_c2",  {127'b0, bif.host_ready}, 128'd0);
    tick();
    check_eq("rd_ready",   {127'b0, bif.host_ready}, 128'd1);
    check_eq("rd_data",    {96'b0, bif.host_data_read}, 128'h1234_5678);
    check_eq("rd_error",   {127'b0, bif.host_error}, 128'd0);
    check_eq("rd_ren_end", {124'b0, bif.device_ren}, 128'd0);
    idle_host();
    tick();
    check_eq("rd_idle",    {127'b0, bif.host_ready}, 128'd0);

    // Write into the overlap region: device 2 must win over device 3.
    bif.host_address    = 32'h2000_0004;
    bif.host_data_write = 32'hAABB_CCDD;
    bif.host_write_mask = 4'b0011;
    bif.host_wen        = 1'b1;
    tick();
    check_eq("wr_wen",   {124'b0, bif.device_wen}, 128'b0100);
    check_eq("wr_ren",   {124'b0, bif.device_ren}, 128'd0);
    check_eq("wr_wdata", bif.device_data_write, {4{32'hAABB_CCDD}});
    check_eq("wr_mask",  {112'b0, bif.device_write_mask}, {112'b0, {4{4'b0011}}});
    check_eq("wr_addr",  bif.device_address, {4{32'h2000_0004}});
    tick();
    tick();
    check_eq("wr_ready", {127'b0, bif.host_ready}, 128'd1);
    check_eq("wr_rdata", {96'b0, bif.host_data_read}, 128'd0);
    check_eq("wr_error", {127'b0, bif.host_error}, 128'd0);
    idle_host();
    tick();

    // Unmapped read.
    bif.host_address = 32'h9000_0000;
    bif.host_ren     = 1'b1;
    tick();
    check_eq("um_ready",  {127'b0, bif.host_ready}, 128'd1);
    check_eq("um_error",  {127'b0, bif.host_error}, 128'd1);
    check_eq("um_rdata",  {96'b0, bif.host_data_read}, 128'hDEAD_BEEF);
    check_eq("um_strobe", {120'b0, bif.device_ren, bif.device_wen}, 128'd0);
    idle_host();
    tick();
    check_eq("um_errcnt", {112'b0, err_count}, 128'd1);
    check_eq("um_erradr", {96'b0, err_addr}, 128'h9000_0000);
    check_eq("um_strb2",  {120'b0, bif.device_ren, bif.device_wen}, 128'd0);

    // Silent device 1: strobe held for exactly eight cycles, then timeout.
    silent           = 4'b0010;
    bif.host_address = 32'h1000_0040;
    bif.host_ren     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("to_ren_c%0d", k), {124'b0, bif.device_ren}, 128'b0010);
      check_eq($sformatf("to_rdy_c%0d", k), {127'b0, bif.host_ready}, 128'd0);
    end
    tick();
    check_eq("to_ren_end", {124'b0, bif.device_ren}, 128'd0);
    check_eq("to_ready",   {127'b0, bif.host_ready}, 128'd1);
    check_eq("to_error",   {127'b0, bif.host_error}, 128'd1);
    check_eq("to_rdata",   {96'b0, bif.host_data_read}, 128'hDEAD_BEEF);
    idle_host();
    silent = '0;
    tick();
    check_eq("to_errcnt",  {112'b0, err_count}, 128'd2);
    check_eq("to_erradr",  {96'b0, err_addr}, 128'h1000_0040);

    // Write and read together: write wins.
    bif.host_address    = 32'h1000_0000;
    bif.host_data_write = 32'h0102_0304;
    bif.host_write_mask = 4'b1111;
    bif.host_wen        = 1'b1;
    bif.host_ren        = 1'b1;
    tick();
    check_eq("wr2_wen", {124'b0, bif.device_wen}, 128'b0010);
    check_eq("wr2_ren", {124'b0, bif.device_ren}, 128'd0);
    tick();
    tick();
    check_eq("wr2_ready", {127'b0, bif.host_ready}, 128'd1);
    check_eq("wr2_rdata", {96'b0, bif.host_data_read}, 128'd0);
    check_eq("wr2_error", {127'b0, bif.host_error}, 128'd0);
    idle_host();
    tick();

    // Bulk unmapped errors with the request held: one error per two cycles.
    bif.host_address = 32'hA000_0100;
    bif.host_ren     = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      tick();
    end
    idle_host();
    tick();
    check_eq("bulk_errcnt", {112'b0, err_count}, 128'd3002);
    check_eq("bulk_erradr", {96'b0, err_addr}, 128'hA000_0100);

    // Saturation: preload the counter near its top, then keep erroring.
    force dut.err_count_q = 16'hFFFD;
    tick();
    release dut.err_count_q;
    tick();
    check_eq("sat_pre", {112'b0, err_count}, 128'hFFFD);
    bif.host_ren = 1'b1;
    tick(); tick();
    check_eq("sat_fffe", {112'b0, err_count}, 128'hFFFE);
    tick(); tick();
    check_eq("sat_ffff", {112'b0, err_count}, 128'hFFFF);
    tick(); tick();
    check_eq("sat_hold", {112'b0, err_count}, 128'hFFFF);
    idle_host();
    tick();

    // Reset in ACTIVE aborts the read and clears the error status.
    bif.host_address = 32'h0000_0010;
    bif.host_ren     = 1'b1;
    tick();
    check_eq("ra_active", {124'b0, bif.device_ren}, 128'b0001);
    rst = 1'b0;
    idle_host();
    tick();
    check_eq("ra_strobe", {120'b0, bif.device_ren, bif.device_wen}, 128'd0);
    check_eq("ra_ready",  {127'b0, bif.host_ready}, 128'd0);
    check_eq("ra_errcnt", {112'b0, err_count}, 128'd0);
    check_eq("ra_erradr", {96'b0, err_addr}, 128'd0);
    tick();
    check_eq("ra_ready2", {127'b0, bif.host_ready}, 128'd0);
    rst = 1'b1;
    tick();
    check_eq("ra_ready3", {127'b0, bif.host_ready}, 128'd0);
    bif.host_ren = 1'b1;
    tick();
    check_eq("pr_ren",  {124'b0, bif.device_ren}, 128'b0001);
    tick();
    tick();
    check_eq("pr_ready", {127'b0, bif.host_ready}, 128'd1);
    check_eq("pr_data",  {96'b0, bif.host_data_read}, 128'h1234_5678);
    check_eq("pr_error", {127'b0, bif.host_error}, 128'd0);
    idle_host();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
